// File: rtl/bin_accumulator.sv
// Frame accumulator: sums pitch-shifted complex bins into NBINS saturating bins,
// then streams the frame out in bin order before accepting the next frame.
module bin_accumulator #(
  parameter int NBINS = 2048,
  parameter int DW    = 44,
  localparam int IW   = $clog2(NBINS),
  localparam int HW   = DW / 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [IW-1:0] in_index,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_index,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          frame_sat,
  output logic [1:0]    fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; a source holds its payload stable while valid=1 and ready=0.

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [IW:0]   CNT_LAST = (IW+1)'(NBINS - 1);
  localparam logic [IW:0]   CNT_ONE  = (IW+1)'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NBINS - 1);
  localparam logic [HW-1:0] SMAX     = {1'b0, {(HW-1){1'b1}}};
  localparam logic [HW-1:0] SMIN     = {1'b1, {(HW-1){1'b0}}};

  state_t          state;
  logic [IW:0]     in_count;
  logic [NBINS-1:0] written;
  logic            sat_flag;

  logic [DW-1:0]   mem [NBINS];
  logic [DW-1:0]   rd_q;
  logic            rd_written;

  logic            p_valid;
  logic            p_fwd;
  logic [IW-1:0]   p_index;
  logic [DW-1:0]   p_data;
  logic [DW-1:0]   last_sum;

  logic [IW:0]     drain_addr;
  logic            r_valid;
  logic [IW-1:0]   r_index;

  logic            accept;
  logic            adv;
  logic            drain_rd;
  logic            rd_en;
  logic [IW-1:0]   rd_addr;
  logic [DW-1:0]   base;
  logic [HW:0]     re_r;
  logic [HW:0]     im_r;
  logic [DW-1:0]   sum;
  logic            ovf;

  // Returns {overflow, saturated sum} of two signed HW-bit values.
  function automatic logic [HW:0] sat_add(input logic [HW-1:0] a, input logic [HW-1:0] b);
    logic [HW:0] s;
    s = {a[HW-1], a} + {b[HW-1], b};
    if (s[HW] != s[HW-1])
      sat_add = {1'b1, (s[HW] ? SMIN : SMAX)};
    else
      sat_add = {1'b0, s[HW-1:0]};
  endfunction

  assign in_ready  = (state == FILL);
  assign fsm_state = state;
  assign accept    = in_valid & in_ready;
  assign adv       = (state == DRAIN) && (!out_valid || out_ready);
  assign drain_rd  = adv && !drain_addr[IW];
  assign rd_en     = accept | drain_rd;
  assign rd_addr   = accept ? in_index : drain_addr[IW-1:0];

  // The read issued alongside the previous accept misses that input's write,
  // so a same-index follower takes the previous sum instead of memory.
  always_comb begin
    base = '0;
    if (p_fwd)
      base = last_sum;
    else if (rd_written)
      base = rd_q;
    re_r = sat_add(base[DW-1:HW], p_data[DW-1:HW]);
    im_r = sat_add(base[HW-1:0], p_data[HW-1:0]);
    sum  = {re_r[HW-1:0], im_r[HW-1:0]};
    ovf  = re_r[HW] | im_r[HW];
  end

  always_ff @(posedge clk) begin
    if (p_valid)
      mem[p_index] <= sum;
    if (rd_en)
      rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      in_count   <= '0;
      written    <= '0;
      sat_flag   <= 1'b0;
      rd_written <= 1'b0;
      p_valid    <= 1'b0;
      p_fwd      <= 1'b0;
      p_index    <= '0;
      p_data     <= '0;
      last_sum   <= '0;
      drain_addr <= '0;
      r_valid    <= 1'b0;
      r_index    <= '0;
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_sat  <= 1'b0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_index <= in_index;
        p_data  <= in_data;
        p_fwd   <= p_valid && (p_index == in_index);
      end
      if (p_valid) begin
        last_sum         <= sum;
        written[p_index] <= 1'b1;
        if (ovf)
          sat_flag <= 1'b1;
      end
      if (rd_en)
        rd_written <= written[rd_addr];

      case (state)
        FILL: begin
          if (accept) begin
            in_count <= in_count + CNT_ONE;
            if (in_count == CNT_LAST)
              state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!p_valid) begin
            state      <= DRAIN;
            drain_addr <= '0;
            r_valid    <= 1'b0;
            frame_sat  <= sat_flag;
          end
        end
        DRAIN: begin
          // Read stage and output register advance together, so a stall
          // simply freezes both and the held read needs no replay.
          if (adv) begin
            r_valid <= drain_rd;
            if (drain_rd) begin
              r_index    <= drain_addr[IW-1:0];
              drain_addr <= drain_addr + CNT_ONE;
            end
            out_valid <= r_valid;
            if (r_valid) begin
              out_index <= r_index;
              out_data  <= rd_written ? rd_q : '0;
              out_last  <= (r_index == IDX_LAST);
            end
          end
          if (out_valid && out_ready && out_last) begin
            state     <= FILL;
            written   <= '0;
            sat_flag  <= 1'b0;
            in_count  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_sat <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_accumulator.sv
// Bench for bin_accumulator: directed frames checked from a vector table plus
// random frames checked against an array-based saturating accumulation model.
module tb_bin_accumulator;

  localparam int NBINS = 2048;
  localparam int DW    = 44;
  localparam int IW    = 11;
  localparam int HW    = 22;
  localparam longint MAXP = (longint'(1) << (HW - 1)) - 1;
  localparam longint MINN = -(longint'(1) << (HW - 1));

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [IW-1:0] in_index;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          frame_sat;
  logic [1:0]    fsm_state;

  bin_accumulator #(.NBINS(NBINS), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_index(in_index), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_data(out_data), .out_last(out_last), .frame_sat(frame_sat),
    .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  longint m_re [NBINS];
  longint m_im [NBINS];
  bit     m_sat;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_word [NBINS];
  bit     got_sat;

  typedef struct {
    int     frame;
    int     bin;
    longint re;
    longint im;
    bit     sat;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack(input longint re, input longint im);
    logic [63:0] a;
    logic [63:0] b;
    a = re;
    b = im;
    return {a[HW-1:0], b[HW-1:0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NBINS; i++) begin
      m_re[i] = 0;
      m_im[i] = 0;
    end
    m_sat = 0;
  endtask

  task automatic model_add(input int idx, input longint re, input longint im);
    longint s;
    s = m_re[idx] + re;
    if (s > MAXP) begin s = MAXP; m_sat = 1; end
    if (s < MINN) begin s = MINN; m_sat = 1; end
    m_re[idx] = s;
    s = m_im[idx] + im;
    if (s > MAXP) begin s = MAXP; m_sat = 1; end
    if (s < MINN) begin s = MINN; m_sat = 1; end
    m_im[idx] = s;
  endtask

  task automatic gen(input int kind, input int k, output int idx, output longint re, output longint im);
    idx = 0; re = 0; im = 0;
    case (kind)
      0: begin idx = k; re = k; im = -k; end
      1: if (k < 2) begin idx = 5; re = (k == 0) ? 100 : 200; end
      2: begin
        if (k < 2) begin idx = 7; re = MAXP; end
        else if (k < 4) begin idx = 7; im = MINN; end
      end
      3: begin
        idx = $urandom_range(0, NBINS - 1);
        re  = longint'($urandom_range(0, 2000)) - 1000;
        im  = longint'($urandom_range(0, 2000)) - 1000;
      end
      4: begin
        idx = $urandom_range(0, 15);
        re  = longint'($urandom_range(0, 32'((1 << HW) - 1))) + MINN;
        im  = longint'($urandom_range(0, 32'((1 << HW) - 1))) + MINN;
      end
      default: if (k < 8) begin
        idx = $urandom_range(1, NBINS - 1);
        re  = longint'($urandom_range(0, 200)) - 100;
        im  = longint'($urandom_range(0, 200)) - 100;
      end
    endcase
  endtask

  // Leaves in_valid high through the edge that accepts the final input.
  task automatic fill(input int kind, input int count);
    int idx;
    longint re;
    longint im;
    int k;
    int guard;
    k = 0;
    guard = 0;
    gen(kind, 0, idx, re, im);
    while (k < count && guard < 4 * count + 20) begin
      @(negedge clk);
      guard++;
      in_valid = 1'b1;
      in_index = IW'(idx);
      in_data  = pack(re, im);
      #1;
      if (in_ready) begin
        model_add(idx, re, im);
        k++;
        if (k < count) gen(kind, k, idx, re, im);
      end
    end
    check("fill_accepted", k, count);
  endtask

  // mode 0: out_ready=1, 1: toggling 1,0,..., 2: random.
  task automatic drain(input int mode, input int rst_at, input bit noise);
    int n;
    int cyc;
    int first_cyc;
    int gaps;
    bit stalled;
    logic [DW-1:0] hold_d;
    logic [IW-1:0] hold_i;
    exp_q.delete();
    for (int b = 0; b < NBINS; b++) exp_q.push_back(pack(m_re[b], m_im[b]));
    n = 0; cyc = 0; first_cyc = -1; gaps = 0; stalled = 0;
    hold_d = '0; hold_i = '0;
    while (n < NBINS && cyc < 4 * NBINS + 50) begin
      @(negedge clk);
      cyc++;
      in_valid = noise;
      if (noise) begin
        in_index = IW'($urandom_range(0, NBINS - 1));
        in_data  = pack($urandom_range(0, 5000), $urandom_range(0, 5000));
        check("ignore_ready", in_ready, 0);
      end
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, hold_d);
        check("stall_index", out_index, hold_i);
      end
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (!out_valid && first_cyc >= 0) gaps++;
      if (rst_at >= 0 && n == rst_at) begin
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_state", fsm_state, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        model_clear();
        return;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = cyc[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        check("bin_data", out_data, exp_q.pop_front());
        check("bin_index", out_index, n);
        check("bin_last", out_last, (n == NBINS - 1));
        check("bin_sat", frame_sat, m_sat);
        got_word[n] = out_data;
        got_sat = frame_sat;
        n++;
        stalled = 0;
      end else begin
        stalled = out_valid;
        hold_d = out_data;
        hold_i = out_index;
      end
    end
    check("drain_count", n, NBINS);
    if (mode == 0) begin
      check("first_latency_ok", (first_cyc >= 0 && first_cyc <= 6), 1);
      check("throughput_gaps", gaps, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("refill_ready", in_ready, 1);
    check("refill_out_valid", out_valid, 0);
  endtask

  task automatic run_frame(input int kind, input int mode, input int rst_at, input bit noise);
    model_clear();
    fill(kind, NBINS);
    drain(mode, rst_at, noise);
  endtask

  task automatic check_table(input int f);
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].frame == f) begin
        if (vecs[v].bin >= 0)
          check($sformatf("vec%0d_bin%0d", v, vecs[v].bin), got_word[vecs[v].bin],
                pack(vecs[v].re, vecs[v].im));
        check($sformatf("vec%0d_sat", v), got_sat, vecs[v].sat);
      end
    end
  endtask

  initial begin
    vecs[0] = '{1, 0,    0,    0,     0};
    vecs[1] = '{1, 1000, 1000, -1000, 0};
    vecs[2] = '{1, 2047, 2047, -2047, 0};
    vecs[3] = '{2, 5,    300,  0,     0};
    vecs[4] = '{2, 6,    0,    0,     0};
    vecs[5] = '{2, 0,    0,    0,     0};
    vecs[6] = '{3, 7,    MAXP, MINN,  1};
    vecs[7] = '{3, 6,    0,    0,     1};
    vecs[8] = '{4, -1,   0,    0,     0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_index = '0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_index", out_index, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_last", out_last, 0);
    check("reset_frame_sat", frame_sat, 0);
    check("reset_state", fsm_state, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);

    run_frame(0, 0, -1, 0);  check_table(1);
    run_frame(1, 0, -1, 0);  check_table(2);
    run_frame(2, 1, -1, 1);  check_table(3);
    run_frame(3, 2, -1, 0);  check_table(4);
    run_frame(4, 0, -1, 0);
    run_frame(4, 0, 1000, 0);
    run_frame(5, 2, -1, 0);

    model_clear();
    fill(3, 500);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("fill_rst_state", fsm_state, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("fill_rst_ready", in_ready, 1);
    run_frame(5, 0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_accumulator.md
BIN_ACCUMULATOR -- requirements
Module: bin_accumulator

Interface
REQ-001 SHALL have parameter NBINS, default 2048, number of frequency bins per frame (power of 2).
REQ-002 SHALL have parameter DW, default 44, bin word width; the upper DW/2 bits are signed real and the lower DW/2 bits are signed imag.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports: in_valid  in  1  pitch-shifted bin present.
REQ-006 SHALL have ports: in_index  in  log2(NBINS)  destination bin index from the pitch-shift stage.
REQ-007 SHALL have ports: in_data  in  DW  bin value to add at in_index.
REQ-008 SHALL have ports: in_ready  out  1  block accepts input this cycle.
REQ-009 SHALL have ports: out_valid  out  1  output bin present.
REQ-010 SHALL have ports: out_ready  in  1  downstream (IFFT) accepts output.
REQ-011 SHALL have ports: out_index  out  log2(NBINS)  bin number of out_data.
REQ-012 SHALL have ports: out_data  out  DW  accumulated bin value.
REQ-013 SHALL have ports: out_last  out  1  marks bin NBINS-1.
REQ-014 SHALL have ports: frame_sat  out  1  current output frame had at least one saturating add.

Function
REQ-015 SHALL implement states FILL, FLUSH and DRAIN; the reset state is FILL.
REQ-016 In FILL, in_ready SHALL be 1; an input is accepted when in_valid & in_ready.
REQ-017 Each accepted input SHALL add in_data into bin[in_index] (read-modify-write); a bin not yet written this frame SHALL be treated as 0, tracked by a per-bin written bit.
REQ-018 Re and im SHALL be added independently as signed DW/2-bit values, saturating to [-2^(DW/2-1), 2^(DW/2-1)-1]; any saturation SHALL set the frame's sat flag.
REQ-019 Back-to-back accepted inputs to the same index, and inputs to an index whose write is still in the pipeline, SHALL accumulate exactly, via forwarding or stall; any stall SHALL be shown as in_ready=0.
REQ-020 An input counter SHALL count accepted inputs; the NBINS-th accepted input SHALL move the state FILL->FLUSH.
REQ-021 FLUSH SHALL hold in_ready=0 until all pending writes retire, then move to DRAIN; FLUSH SHALL last at most 3 cycles.
REQ-022 DRAIN SHALL emit bins 0..NBINS-1 in ascending order, one per out_valid&out_ready handshake; unwritten bins SHALL emit 0.
REQ-023 out_valid, out_index, out_data, out_last and frame_sat SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-024 Throughput SHALL be 1 bin/cycle when out_ready is held at 1, after a read latency of at most 2 cycles from DRAIN entry to the first out_valid.
REQ-025 out_last SHALL be 1 only with out_index=NBINS-1; frame_sat SHALL be constant for the whole drained frame.
REQ-026 The handshake of bin NBINS-1 SHALL clear all written bits, the sat flag and the input counter, and SHALL return to FILL with in_ready=1 on the next cycle.
REQ-027 In FLUSH and DRAIN, in_ready SHALL be 0 and in_valid SHALL be ignored without side effects.
REQ-028 Index wrap SHALL be impossible: in_index is width-limited to the bin range and the counter SHALL be exactly log2(NBINS)+1 bits.

Reset
REQ-029 While rst=1, asynchronously: state=FILL, counters=0, all written bits=0, sat flag=0, in_ready=1 (once rst deasserts), out_valid=0, out_index=0, out_data=0, out_last=0, frame_sat=0.
REQ-030 rst asserted mid-FILL or mid-DRAIN SHALL discard the partial frame; the first frame after reset SHALL see all bins as 0.
REQ-031 Memory contents need not be reset; the written bits alone SHALL guarantee zero reads.

Verification
REQ-032 Identity: 2048 inputs with index=i, re=i, im=-i, out_ready=1 -> 2048 outputs with out_index=i, re=i, im=-i; out_last only at i=2047; frame_sat=0.
REQ-033 Collision: index 5 given re=100 then re=200 on consecutive cycles, index 6 never given, remaining inputs to bin 0 with data 0 -> bin5 re=300; bin6=0.
REQ-034 Saturation: two writes of re=0x1FFFFF to bin 7 -> bin7 re=0x1FFFFF (max positive); two writes of im=-0x200000 -> im=-0x200000; frame_sat=1 for the whole frame, 0 on the following clean frame.
REQ-035 Backpressure: out_ready toggled 1,0,1,0 during DRAIN -> exactly 2048 outputs in order, none dropped or duplicated, out_data stable while stalled.
REQ-036 Input ignore and reset: in_valid=1 with data during DRAIN -> no change to the next frame; rst pulse at bin 1000 of DRAIN -> out_valid=0 immediately, in_ready=1 after release, next frame starts at zeroed bins.
